uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_bit_timer.sv | 30 +++
 rtl/uart_tx.sv | 130 +++++++++++++
 tb/tb_uart_tx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: reload on i_load, o_bit_done while the count sits at zero.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    output logic o_bit_done
);

    localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

    logic [15:0] r_count;

    // Count down one bit period; hold at zero until the next reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 16'd0;
        end else if (i_load) begin
            r_count <= RELOAD;
        end else if (r_count != 16'd0) begin
            r_count <= r_count - 16'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_bit_done = (r_count == 16'd0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ack byte intake, start + 8 data (LSB first) + optional parity + stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ack,
    output logic       TxD,
    output logic       o_busy
);

    uart_state_t r_state;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_idx;
    logic        r_stop_idx;
    logic        r_parity;
    logic        r_txd;
    logic        r_ack;
    logic        r_busy;
    logic        w_load;
    logic        w_bit_done;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .o_bit_done(w_bit_done)
    );

    // Reload the timer on acceptance and at every bit boundary.
    always_comb begin
        w_load = 1'b0;
        if (r_state == ST_IDLE) begin
            w_load = tx_data_valid;
        end else begin
            w_load = w_bit_done;
        end
    end

    // Frame sequencer; TxD, ack and busy are all registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= 8'd0;
            r_bit_idx  <= 3'd0;
            r_stop_idx <= 1'b0;
            r_parity   <= 1'b0;
            r_txd      <= 1'b1;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tx_data_valid) begin
                        r_shift  <= tx_data;
                        r_parity <= parity_bit(tx_data, PARITY);
                        r_ack    <= 1'b1;
                        r_busy   <= 1'b1;
                        r_txd    <= 1'b0;
                        r_state  <= ST_START;
                    end else begin
                        r_txd  <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_bit_done) begin
                        r_txd     <= r_shift[0];
                        r_bit_idx <= 3'd0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bit_done) begin
                        if (r_bit_idx == 3'd7) begin
                            if (PARITY != PARITY_NONE) begin
                                r_txd   <= r_parity;
                                r_state <= ST_PARITY;
                            end else begin
                                r_txd      <= 1'b1;
                                r_stop_idx <= 1'b0;
                                r_state    <= ST_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_txd     <= r_shift[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bit_done) begin
                        r_txd      <= 1'b1;
                        r_stop_idx <= 1'b0;
                        r_state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_bit_done) begin
                        if (r_stop_idx == 1'(STOP_BITS - 1)) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_stop_idx <= r_stop_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign TxD         = r_txd;
    assign tx_data_ack = r_ack;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Three uart_tx configurations checked cycle by cycle against a frame-level reference model.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data [3];
    logic [2:0] tx_valid;
    logic [2:0] ack;
    logic [2:0] txd;
    logic [2:0] busy;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .tx_data(tx_data[0]), .tx_data_valid(tx_valid[0]),
        .tx_data_ack(ack[0]), .TxD(txd[0]), .o_busy(busy[0]));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .tx_data(tx_data[1]), .tx_data_valid(tx_valid[1]),
        .tx_data_ack(ack[1]), .TxD(txd[1]), .o_busy(busy[1]));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) dut2 (
        .clk(clk), .reset(reset), .tx_data(tx_data[2]), .tx_data_valid(tx_valid[2]),
        .tx_data_ack(ack[2]), .TxD(txd[2]), .o_busy(busy[2]));

    int vectors = 0;
    int miscompares = 0;

    // reference model: position within the current frame (-1 = idle) and the frame's bit levels
    int          m_t [3];
    int          m_len [3];
    logic [11:0] m_frame [3];
    logic        m_ack [3];

    // observed-run statistics for the directed length/gap/parity checks
    int   brun [3], gap [3], last_busy [3], last_gap [3], acks [3];
    logic par_seen [3];
    logic prev_busy [3];

    logic [7:0] msg [$];
    int         idx [3];
    int         gap_pct = 0;
    bit         req_on = 1'b0;

    function automatic int par_of(input int k);
        return k;
    endfunction

    function automatic int stop_of(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input int k, input logic [7:0] d);
        m_frame[k]      = 12'hFFF;
        m_frame[k][0]   = 1'b0;
        m_frame[k][8:1] = d;
        if (par_of(k) == 1) m_frame[k][9] = ^d;
        if (par_of(k) == 2) m_frame[k][9] = ~(^d);
        m_len[k] = (9 + ((par_of(k) != 0) ? 1 : 0) + stop_of(k)) * CPB;
        m_t[k]   = 0;
        m_ack[k] = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            m_ack[k] = 1'b0;
            if (reset) m_t[k] = -1;
            else if (m_t[k] < 0) begin
                if (tx_valid[k]) model_accept(k, tx_data[k]);
            end else begin
                m_t[k]++;
                if (m_t[k] == m_len[k]) m_t[k] = -1;
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("txd%0d", k), {31'd0, txd[k]},
                (m_t[k] < 0) ? 32'd1 : {31'd0, m_frame[k][m_t[k] / CPB]});
            chk($sformatf("busy%0d", k), {31'd0, busy[k]}, (m_t[k] >= 0) ? 32'd1 : 32'd0);
            chk($sformatf("ack%0d", k), {31'd0, ack[k]}, {31'd0, m_ack[k]});
            if (ack[k]) acks[k]++;
            if (busy[k]) begin
                if (!prev_busy[k]) begin
                    last_gap[k] = gap[k];
                    brun[k] = 0;
                end
                brun[k]++;
                if (brun[k] == 38) par_seen[k] = txd[k];
                gap[k] = 0;
            end else begin
                if (prev_busy[k]) last_busy[k] = brun[k];
                gap[k]++;
            end
            prev_busy[k] = busy[k];
            // requester: holds valid and data until it sees the ack
            if (req_on && !reset) begin
                if (tx_valid[k] && ack[k]) tx_valid[k] = 1'b0;
                if (!tx_valid[k] && idx[k] < msg.size() && $urandom_range(99) >= gap_pct) begin
                    tx_valid[k] = 1'b1;
                    tx_data[k]  = msg[idx[k]];
                    idx[k]++;
                end else if (!tx_valid[k]) begin
                    tx_data[k] = 8'($urandom);
                end
            end
        end
    endtask

    function automatic bit all_done();
        for (int k = 0; k < 3; k++)
            if (idx[k] < msg.size() || tx_valid[k] || m_t[k] >= 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_done(input int budget);
        int n = 0;
        while (n < budget && !all_done()) begin
            tick();
            n++;
        end
        chk("drain_in_budget", {31'd0, (n < budget)}, 32'd1);
        repeat (2) tick();
    endtask

    initial begin
        int exp_len [3] = '{40, 48, 44};
        logic exp_par [3] = '{1'b1, 1'b1, 1'b0};
        int n;
        tx_valid = 3'b000;
        for (int k = 0; k < 3; k++) begin
            tx_data[k] = 8'd0; idx[k] = 0; m_t[k] = -1; m_len[k] = 0; m_frame[k] = 12'hFFF;
            m_ack[k] = 1'b0; brun[k] = 0; gap[k] = 0; last_busy[k] = 0; last_gap[k] = 0;
            acks[k] = 0; par_seen[k] = 1'b0; prev_busy[k] = 1'b0;
        end

        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        // single byte 0x61: frame length, one ack, parity level
        req_on = 1'b1;
        msg.push_back(8'h61);
        run_done(300);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("frame_len%0d", k), last_busy[k], exp_len[k]);
            chk($sformatf("acks_61_%0d", k), acks[k], 32'd1);
            chk($sformatf("parity_61_%0d", k), {31'd0, par_seen[k]}, {31'd0, exp_par[k]});
        end

        // valid held high: 0x55 then 0xAA back to back
        for (int k = 0; k < 3; k++) acks[k] = 0;
        msg.push_back(8'h55);
        msg.push_back(8'hAA);
        run_done(400);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("acks_b2b_%0d", k), acks[k], 32'd2);
            chk($sformatf("idle_gap%0d", k), last_gap[k], 32'd1);
        end

        // reset during data bit 3 of 0x0F, then 0x30
        msg.push_back(8'h0F);
        n = 0;
        while (brun[0] != 18 && n < 200) begin
            tick();
            n++;
        end
        chk("reach_data_bit3", {31'd0, (brun[0] == 18)}, 32'd1);
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_txd%0d", k), {31'd0, txd[k]}, 32'd1);
            chk($sformatf("rst_busy%0d", k), {31'd0, busy[k]}, 32'd0);
            chk($sformatf("rst_ack%0d", k), {31'd0, ack[k]}, 32'd0);
            m_t[k] = -1;
            m_ack[k] = 1'b0;
            acks[k] = 0;
        end
        repeat (2) tick();
        reset = 1'b0;
        msg.push_back(8'h30);
        run_done(300);
        for (int k = 0; k < 3; k++)
            chk($sformatf("acks_after_rst%0d", k), acks[k], 32'd1);

        // randomized requester: "a".."z" wrapping
        gap_pct = 60;
        for (int i = 0; i < 60; i++) msg.push_back(8'h61 + 8'(i % 26));
        run_done(20000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
